mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-to-one arbiter that shares the single SRAM-like memory port between the instruction-fetch stage and the EX-stage data access (the `ram_req` / `mem_addr_ok` path). It sits between the core pipeline and the memory bridge. The request path is combinational with no added latency. A small in-order tracking queue routes each `data_ok` and its read data back to the requester that issued the transaction. Responses belonging to fetches that were flushed by a redirect are discarded.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `MAX_OUT`, 4: maximum outstanding transactions; power of two, at least 2.

- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `d_req`, `d_wr` in 1 each: data request; write when `d_wr`=1.
- `d_addr` in ADDR_WIDTH; `d_wdata` in DATA_WIDTH; `d_wstrb` in DATA_WIDTH/8: data request payload.
- `d_addr_ok`, `d_data_ok` out 1 each: data request accepted / data response valid.
- `d_rdata` out DATA_WIDTH: data read result.
- `i_req` in 1; `i_addr` in ADDR_WIDTH: fetch request (always a read).
- `i_addr_ok`, `i_data_ok` out 1 each: fetch request accepted / fetch response valid.
- `i_rdata` out DATA_WIDTH: fetched instruction.
- `i_cancel` in 1: flush pulse; discards every outstanding fetch response.
- `m_req`, `m_wr` out 1 each; `m_addr` out ADDR_WIDTH; `m_wdata` out DATA_WIDTH; `m_wstrb` out DATA_WIDTH/8: downstream request.
- `m_addr_ok`, `m_data_ok` in 1 each; `m_rdata` in DATA_WIDTH: downstream handshake and read data.
- `resp_err` out 1: sticky flag; set when `m_data_ok` arrives while the queue is empty.

## Operation
- **Priority.** Fixed: data beats fetch. An exception is the lock rule below.
- **Lock.** A grant is locked while `m_req`=1 and `m_addr_ok`=0.
  - The state is `lock_v` plus `lock_id` (0 = data, 1 = fetch).
  - The locked requester keeps the grant next cycle, even if the other one requests.
  - If the locked requester drops its req, the lock clears and arbitration is redone in the same cycle.
- **Full queue.** When the queue holds MAX_OUT entries at the start of a cycle, `m_req`=0 and both `*_addr_ok`=0. Same-cycle pop does not free a slot for push.
- **Request mux.** `m_*` carry the granted requester's payload. When a fetch is granted: `m_wr`=0, `m_wstrb`=0.
- **Accept.** The granted requester sees `*_addr_ok` = `m_addr_ok`; the other requester sees 0.
- **Tracking queue.** FIFO with MAX_OUT entries; each entry is `{id, discard}`.
  - Push on `m_req & m_addr_ok`.
  - Pop on `m_data_ok`.
  - Pointers wrap modulo MAX_OUT; count width is log2(MAX_OUT)+1.
- **Response routing.** Based on the head entry:
  - id 0: `d_data_ok` = `m_data_ok`.
  - id 1 with discard=0: `i_data_ok` = `m_data_ok`.
  - id 1 with discard=1: the entry is popped silently; neither `*_data_ok` asserts.
  - `d_rdata` and `i_rdata` both equal `m_rdata` (unqualified).
- **Cancel.** `i_cancel` sets `discard` on every valid fetch entry, including:
  - a fetch pushed in the same cycle;
  - the head entry popped in the same cycle, whose `i_data_ok` is suppressed.
- **Empty-queue response.** `m_data_ok` with an empty queue sets `resp_err`, pops nothing and forwards nothing. `resp_err` clears only on reset.

## Timing
- **Reset values.** Synchronous reset clears:
  - queue count and pointers;
  - all discard bits;
  - `lock_v`;
  - `resp_err`.
  
  Consequently `m_req`, all `*_addr_ok` and all `*_data_ok` read 0 until a requester asserts. The downstream bridge shares `rst_n`.
- **Latency.** Zero cycles request-to-`m_req` and `m_data_ok`-to-`*_data_ok`; all forward paths are combinational.
- **Grant decision.** Made from the current cycle's `d_req`, `i_req`, `lock_v`, `lock_id` and count.
- **Registered state.** The lock, queue and `resp_err` update on the rising edge.
- **Throughput.**
  - One accept per cycle when the queue is not full.
  - Back-to-back accepts up to MAX_OUT.
  - One response per cycle.
  - Push and pop together in one cycle keep the count unchanged.
- **Response order.** Responses are in order; the bridge must return responses in acceptance order.

## Structure
- Shared package `mem_bus_pkg`:
  - requester id constants `REQ_DATA`=0, `REQ_FETCH`=1;
  - MAX_OUT default;
  - queue-entry typedef `{id, discard}`.
- Natural sub-module: `mem_req_queue`, a parameterized FIFO with a broadcast "mark all id==1 discard" input and full/empty/head outputs.
- The arbiter top holds the lock FSM, payload mux, response demux and `resp_err`.

## Test plan
- **Simultaneous requests.** `d_req`=`i_req`=1, `m_addr_ok`=1 → data granted: `m_addr`=`d_addr`, `d_addr_ok`=1, `i_addr_ok`=0; fetch granted the next cycle.
- **Lock.** Fetch presented, `m_addr_ok`=0 for 3 cycles, `d_req` rises in cycle 2 → `m_addr` stays `i_addr` until `m_addr_ok`; data is granted the cycle after.
- **Queue full.** MAX_OUT=4; accept 4 fetches, no `m_data_ok` → 5th cycle `m_req`=0, `i_addr_ok`=0. One `m_data_ok` → accept resumes the following cycle.
- **Cancel.** Queue holds fetch, data, fetch; `i_cancel` pulses, then 3 `m_data_ok` → only `d_data_ok` pulses (2nd response); `i_data_ok` stays 0; the queue ends empty.
- **Empty-queue response.** `m_data_ok` with the queue empty → `resp_err`=1 and held; after reset → `resp_err`=0, `m_req`=0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the memory-port arbiter.
// Requester ids, default queue depth and tracking-queue entry.
package mem_bus_pkg;

  localparam logic REQ_DATA  = 1'b0;
  localparam logic REQ_FETCH = 1'b1;

  localparam int MAX_OUT_DEF = 4;

  typedef struct packed {
    logic id;
    logic discard;
  } q_ent_t;

endpackage

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order tracking FIFO of {id, discard} entries.
// Ports: push/push_id in, pop in, cancel in (mark fetches), head/full/empty out.
module mem_req_queue
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   push_id,
  input  logic   pop,
  input  logic   cancel,
  output q_ent_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  q_ent_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      // Stale slots may also get marked; a push rewrites the whole entry.
      for (int i = 0; i < DEPTH; i++)
        if (cancel && mem[i].id == REQ_FETCH)
          mem[i].discard <= 1'b1;
      if (push) begin
        mem[wr_ptr].id      <= push_id;
        mem[wr_ptr].discard <= cancel && push_id == REQ_FETCH;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: data/fetch 2:1 arbiter onto one SRAM-like port.
// d_*/i_* requester ports, m_* downstream port, resp_err sticky flag.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUT    = MAX_OUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_req,
  input  logic                    d_wr,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_addr_ok,
  output logic                    d_data_ok,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_addr_ok,
  output logic                    i_data_ok,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    i_cancel,
  output logic                    m_req,
  output logic                    m_wr,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_addr_ok,
  input  logic                    m_data_ok,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    resp_err
);

  logic   lock_v;
  logic   lock_id;
  logic   lock_v_n;
  logic   lock_id_n;
  logic   lock_hold;
  logic   gnt_v;
  logic   gnt_id;
  q_ent_t head;
  logic   q_full;
  logic   q_empty;
  logic   q_push;
  logic   q_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_v  <= 1'b0;
      lock_id <= REQ_DATA;
    end else begin
      lock_v  <= lock_v_n;
      lock_id <= lock_id_n;
    end
  end

  // A stalled grant stays locked until the bridge accepts it.
  always_comb begin
    lock_v_n  = gnt_v && !m_addr_ok;
    lock_id_n = gnt_id;
  end

  always_comb begin
    lock_hold = lock_v &&
      (lock_id == REQ_FETCH ? i_req : d_req);
    gnt_v  = 1'b0;
    gnt_id = REQ_DATA;
    if (q_full) begin
      gnt_v = 1'b0;
    end else if (lock_hold) begin
      gnt_v  = 1'b1;
      gnt_id = lock_id;
    end else if (d_req) begin
      gnt_v  = 1'b1;
      gnt_id = REQ_DATA;
    end else if (i_req) begin
      gnt_v  = 1'b1;
      gnt_id = REQ_FETCH;
    end
    m_req = gnt_v;
    if (gnt_id == REQ_FETCH) begin
      m_wr    = 1'b0;
      m_addr  = i_addr;
      m_wdata = '0;
      m_wstrb = '0;
    end else begin
      m_wr    = d_wr;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_wstrb = d_wstrb;
    end
    d_addr_ok = gnt_v && gnt_id == REQ_DATA && m_addr_ok;
    i_addr_ok = gnt_v && gnt_id == REQ_FETCH && m_addr_ok;
  end

  assign q_push = m_req && m_addr_ok;
  assign q_pop  = m_data_ok && !q_empty;

  mem_req_queue #(
    .DEPTH (MAX_OUT)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (q_push),
    .push_id (gnt_id),
    .pop     (q_pop),
    .cancel  (i_cancel),
    .head    (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  // A cancel in the pop cycle still kills that fetch response.
  assign d_data_ok = q_pop && head.id == REQ_DATA;
  assign i_data_ok = q_pop && head.id == REQ_FETCH &&
                     !head.discard && !i_cancel;
  assign d_rdata   = m_rdata;
  assign i_rdata   = m_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n)
      resp_err <= 1'b0;
    else if (m_data_ok && q_empty)
      resp_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant, lock, full, cancel, error.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_req, d_wr;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        i_cancel;
  logic        m_req, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        resp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_rdata   (d_rdata),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .i_rdata   (i_rdata),
    .i_cancel  (i_cancel),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_addr_ok (m_addr_ok),
    .m_data_ok (m_data_ok),
    .m_rdata   (m_rdata),
    .resp_err  (resp_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    d_req = 0; d_wr = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0;
    i_req = 0; i_addr = 0; i_cancel = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    mid();
    chk("rst_m_req", m_req, 0);
    chk("rst_d_addr_ok", d_addr_ok, 0);
    chk("rst_i_addr_ok", i_addr_ok, 0);
    chk("rst_d_data_ok", d_data_ok, 0);
    chk("rst_i_data_ok", i_data_ok, 0);
    chk("rst_resp_err", resp_err, 0);

    // simultaneous requests: data first
    nxt();
    d_req = 1; d_wr = 1; d_addr = 32'hA000_0010;
    d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    i_req = 1; i_addr = 32'h0000_1000;
    m_addr_ok = 1;
    mid();
    chk("sim_m_req", m_req, 1);
    chk("sim_m_addr", m_addr, 32'hA000_0010);
    chk("sim_m_wr", m_wr, 1);
    chk("sim_m_wdata", m_wdata, 32'h1234_5678);
    chk("sim_m_wstrb", m_wstrb, 4'hF);
    chk("sim_d_addr_ok", d_addr_ok, 1);
    chk("sim_i_addr_ok", i_addr_ok, 0);
    nxt();
    d_req = 0;
    mid();
    chk("sim2_m_addr", m_addr, 32'h0000_1000);
    chk("sim2_m_wr", m_wr, 0);
    chk("sim2_m_wstrb", m_wstrb, 0);
    chk("sim2_i_addr_ok", i_addr_ok, 1);
    chk("sim2_d_addr_ok", d_addr_ok, 0);
    nxt();
    i_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'hDDDD_0001;
    mid();
    chk("rsp1_d_data_ok", d_data_ok, 1);
    chk("rsp1_i_data_ok", i_data_ok, 0);
    chk("rsp1_d_rdata", d_rdata, 32'hDDDD_0001);
    nxt();
    m_rdata = 32'hCCCC_0002;
    mid();
    chk("rsp2_i_data_ok", i_data_ok, 1);
    chk("rsp2_d_data_ok", d_data_ok, 0);
    chk("rsp2_i_rdata", i_rdata, 32'hCCCC_0002);
    nxt();
    m_data_ok = 0;

    // lock: fetch stalled, data arrives later
    i_req = 1; i_addr = 32'h0000_2000;
    mid();
    chk("lk1_m_addr", m_addr, 32'h0000_2000);
    chk("lk1_i_addr_ok", i_addr_ok, 0);
    nxt();
    d_req = 1; d_wr = 0; d_addr = 32'hA000_0020;
    mid();
    chk("lk2_m_addr", m_addr, 32'h0000_2000);
    chk("lk2_d_addr_ok", d_addr_ok, 0);
    nxt();
    mid();
    chk("lk3_m_addr", m_addr, 32'h0000_2000);
    chk("lk3_m_req", m_req, 1);
    nxt();
    m_addr_ok = 1;
    mid();
    chk("lk4_m_addr", m_addr, 32'h0000_2000);
    chk("lk4_i_addr_ok", i_addr_ok, 1);
    chk("lk4_d_addr_ok", d_addr_ok, 0);
    nxt();
    i_req = 0;
    mid();
    chk("lk5_m_addr", m_addr, 32'hA000_0020);
    chk("lk5_d_addr_ok", d_addr_ok, 1);
    nxt();
    d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    mid();
    chk("lkr1_i_data_ok", i_data_ok, 1);
    nxt();
    mid();
    chk("lkr2_d_data_ok", d_data_ok, 1);
    nxt();
    m_data_ok = 0;

    // queue full after four accepts
    i_req = 1; m_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      i_addr = 32'h0000_3000 + 32'(k * 4);
      mid();
      chk("full_acc_i_addr_ok", i_addr_ok, 1);
      nxt();
    end
    m_data_ok = 1;
    mid();
    chk("full_m_req", m_req, 0);
    chk("full_i_addr_ok", i_addr_ok, 0);
    chk("full_pop_i_data_ok", i_data_ok, 1);
    nxt();
    m_data_ok = 0;
    mid();
    chk("resume_m_req", m_req, 1);
    chk("resume_i_addr_ok", i_addr_ok, 1);
    nxt();
    i_req = 0; m_addr_ok = 0; m_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("full_drain_i_data_ok", i_data_ok, 1);
      nxt();
    end
    m_data_ok = 0;

    // cancel with fetch, data, fetch outstanding
    m_addr_ok = 1; i_req = 1; i_addr = 32'h0000_4000;
    nxt();
    i_req = 0; d_req = 1; d_addr = 32'hA000_0040;
    nxt();
    d_req = 0; i_req = 1; i_addr = 32'h0000_4004;
    nxt();
    i_req = 0; m_addr_ok = 0; i_cancel = 1;
    nxt();
    i_cancel = 0; m_data_ok = 1;
    mid();
    chk("cx1_i_data_ok", i_data_ok, 0);
    chk("cx1_d_data_ok", d_data_ok, 0);
    nxt();
    mid();
    chk("cx2_d_data_ok", d_data_ok, 1);
    chk("cx2_i_data_ok", i_data_ok, 0);
    nxt();
    mid();
    chk("cx3_i_data_ok", i_data_ok, 0);
    chk("cx3_d_data_ok", d_data_ok, 0);
    nxt();
    m_data_ok = 0;

    // cancel hitting the popped head and a same-cycle push
    i_req = 1; m_addr_ok = 1; i_addr = 32'h0000_5000;
    nxt();
    i_addr = 32'h0000_5004;
    m_data_ok = 1; i_cancel = 1;
    mid();
    chk("cxs_i_data_ok", i_data_ok, 0);
    chk("cxs_i_addr_ok", i_addr_ok, 1);
    nxt();
    i_req = 0; m_addr_ok = 0; i_cancel = 0;
    mid();
    chk("cxp_i_data_ok", i_data_ok, 0);
    chk("cxp_resp_err", resp_err, 0);
    nxt();

    // response with empty queue
    mid();
    chk("emp_d_data_ok", d_data_ok, 0);
    chk("emp_i_data_ok", i_data_ok, 0);
    nxt();
    m_data_ok = 0;
    mid();
    chk("emp_resp_err", resp_err, 1);
    nxt();
    mid();
    chk("emp_resp_err_held", resp_err, 1);

    // reset clears error
    nxt();
    rst_n = 0;
    nxt();
    rst_n = 1;
    mid();
    chk("rst2_resp_err", resp_err, 0);
    chk("rst2_m_req", m_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
